// File: rtl/dcache_refill_ctrl.sv
// Miss/refill sequencer for the 2-way data cache: victim pick, optional writeback, 4-beat refill.
// Define DCACHE_LRU_EN for per-set LRU replacement; otherwise a global round-robin bit is used.
module dcache_refill_ctrl #(
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned TAG_W   = 20
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  input  logic [INDEX_W-1:0] req_index,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic [1:0]         hit,
  input  logic [1:0]         way_dirty,
  input  logic [TAG_W-1:0]   way_tag0,
  input  logic [TAG_W-1:0]   way_tag1,
  input  logic [127:0]       way_data0,
  input  logic [127:0]       way_data1,
  output logic               stall,
  output logic               wr_req,
  output logic [31:0]        wr_addr,
  output logic [127:0]       wr_data,
  input  logic               wr_rdy,
  output logic               rd_req,
  output logic [31:0]        rd_addr,
  input  logic               rd_rdy,
  input  logic               ret_valid,
  input  logic               ret_last,
  input  logic [31:0]        ret_data,
  output logic [1:0]         fill_we,
  output logic [INDEX_W-1:0] fill_index,
  output logic [TAG_W-1:0]   fill_tag,
  output logic [127:0]       fill_data,
  output logic               refill_done
);

  localparam int unsigned Sets = 2 ** INDEX_W;

  typedef enum logic [2:0] {StIdle, StWb, StRd, StRecv, StFill} state_e;

  state_e             state_q;
  logic               victim_q;
  logic [INDEX_W-1:0] index_q;
  logic [TAG_W-1:0]   tag_q;
  logic [1:0]         cnt_q;
  logic [127:0]       line_q;
  logic [127:0]       line_nxt;
  logic               victim;

`ifdef DCACHE_LRU_EN
  // One bit per set naming the way to evict next.
  logic [Sets-1:0] lru_q;
  assign victim = lru_q[req_index];
`else
  logic rr_q;
  assign victim = rr_q;
`endif

  assign stall = (state_q != StIdle) || (req_valid && (hit == 2'b00));

  // Line buffer with the current beat merged in, so the last beat lands in fill_data directly.
  always_comb begin
    line_nxt = line_q;
    line_nxt[{cnt_q, 5'd0} +: 32] = ret_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      victim_q    <= 1'b0;
      index_q     <= '0;
      tag_q       <= '0;
      cnt_q       <= 2'd0;
      line_q      <= '0;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      fill_we     <= 2'b00;
      fill_index  <= '0;
      fill_tag    <= '0;
      fill_data   <= '0;
      refill_done <= 1'b0;
`ifdef DCACHE_LRU_EN
      lru_q       <= '0;
`else
      rr_q        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (hit != 2'b00) begin
`ifdef DCACHE_LRU_EN
              // A hit on way1 (or both ways) makes way0 the next victim.
              lru_q[req_index] <= ~hit[1];
`endif
            end else begin
              victim_q <= victim;
              index_q  <= req_index;
              tag_q    <= req_tag;
              rd_addr  <= {req_tag, req_index, 4'h0};
              if (way_dirty[victim]) begin
                wr_req  <= 1'b1;
                wr_addr <= {(victim ? way_tag1 : way_tag0), req_index, 4'h0};
                wr_data <= victim ? way_data1 : way_data0;
                state_q <= StWb;
              end else begin
                rd_req  <= 1'b1;
                state_q <= StRd;
              end
            end
          end
        end
        StWb: begin
          if (wr_req && wr_rdy) begin
            wr_req  <= 1'b0;
            rd_req  <= 1'b1;
            state_q <= StRd;
          end
        end
        StRd: begin
          if (rd_req && rd_rdy) begin
            rd_req  <= 1'b0;
            cnt_q   <= 2'd0;
            line_q  <= '0;
            state_q <= StRecv;
          end
        end
        StRecv: begin
          if (ret_valid) begin
            line_q <= line_nxt;
            cnt_q  <= cnt_q + 2'd1;
            if (ret_last) begin
              fill_we     <= victim_q ? 2'b10 : 2'b01;
              fill_index  <= index_q;
              fill_tag    <= tag_q;
              fill_data   <= line_nxt;
              refill_done <= 1'b1;
              state_q     <= StFill;
            end
          end
        end
        StFill: begin
          fill_we     <= 2'b00;
          refill_done <= 1'b0;
`ifdef DCACHE_LRU_EN
          lru_q[index_q] <= ~victim_q;
`else
          rr_q <= ~rr_q;
`endif
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Randomized self-checking bench for dcache_refill_ctrl against a replacement/refill reference model.
module tb_dcache_refill_ctrl;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid;
  logic [7:0]   req_index;
  logic [19:0]  req_tag;
  logic [1:0]   hit;
  logic [1:0]   way_dirty;
  logic [19:0]  way_tag0, way_tag1;
  logic [127:0] way_data0, way_data1;
  logic         stall;
  logic         wr_req;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic [1:0]   fill_we;
  logic [7:0]   fill_index;
  logic [19:0]  fill_tag;
  logic [127:0] fill_data;
  logic         refill_done;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference replacement state.
  logic         lru_m [256];
  logic         rr_m;
  logic [31:0]  beats [8];

  always #5 clk = ~clk;

  dcache_refill_ctrl #(.INDEX_W(8), .TAG_W(20)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_index(req_index), .req_tag(req_tag),
    .hit(hit), .way_dirty(way_dirty), .way_tag0(way_tag0), .way_tag1(way_tag1),
    .way_data0(way_data0), .way_data1(way_data1), .stall(stall), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .fill_we(fill_we), .fill_index(fill_index), .fill_tag(fill_tag), .fill_data(fill_data),
    .refill_done(refill_done)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic rand_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic model_victim(input logic [7:0] idx);
`ifdef DCACHE_LRU_EN
    return lru_m[idx];
`else
    return rr_m;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) lru_m[i] = 1'b0;
    rr_m = 1'b0;
  endtask

  // Inputs that the controller must ignore while busy get scrambled.
  task automatic scramble_lookup();
    req_valid = rand_bit();
    hit       = 2'($urandom_range(0, 3));
    req_index = 8'($urandom);
    req_tag   = 20'($urandom);
    way_dirty = 2'($urandom_range(0, 3));
    way_tag0  = 20'($urandom);
    way_tag1  = 20'($urandom);
    way_data0 = rand_line();
    way_data1 = rand_line();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {wr_req, rd_req, fill_we, refill_done}, '0);
    check_eq({tag, "_addr"}, {wr_addr, rd_addr, fill_index, fill_tag}, '0);
    check_eq({tag, "_wdata"}, wr_data, '0);
    check_eq({tag, "_fdata"}, fill_data, '0);
    check_eq({tag, "_stall"}, stall, 1'b0);
  endtask

  task automatic run_hit(input logic [7:0] idx, input logic [1:0] h);
    @(posedge clk); #1;
    req_valid = 1'b1; req_index = idx; req_tag = 20'($urandom); hit = h;
    way_dirty = 2'($urandom_range(0, 3));
    wr_rdy = rand_bit(); rd_rdy = rand_bit();
    @(negedge clk);
    check_eq("hit_stall", stall, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0; wr_rdy = 1'b0; rd_rdy = 1'b0;
    @(negedge clk);
    check_eq("hit_noreq", {wr_req, rd_req}, 2'b00);
`ifdef DCACHE_LRU_EN
    lru_m[idx] = ~h[1];
`endif
  endtask

  // abort_at >= 0 pulls reset after that many beats have been returned.
  task automatic run_miss(input logic [7:0] idx, input logic [19:0] tg, input logic [1:0] dirty,
                          input logic [19:0] t0, input logic [19:0] t1,
                          input logic [127:0] d0, input logic [127:0] d1,
                          input int nbeats, input int abort_at);
    logic        v;
    logic [31:0] words [4];
    int          k;
    int          dly;
    v = model_victim(idx);
    for (int i = 0; i < 4; i++) words[i] = '0;
    k = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_index = idx; req_tag = tg; hit = 2'b00; way_dirty = dirty;
    way_tag0 = t0; way_tag1 = t1; way_data0 = d0; way_data1 = d1;
    wr_rdy = rand_bit(); rd_rdy = rand_bit();
    @(negedge clk);
    check_eq("miss_stall", stall, 1'b1);
    check_eq("miss_noreq", {wr_req, rd_req}, 2'b00);
    @(posedge clk); #1;
    scramble_lookup();
    if (dirty[v]) begin
      dly = $urandom_range(0, 3);
      for (int i = 0; i <= dly; i++) begin
        wr_rdy = (i == dly); rd_rdy = rand_bit();
        @(negedge clk);
        check_eq("wb_req", {wr_req, rd_req}, 2'b10);
        check_eq("wb_addr", wr_addr, {(v ? t1 : t0), idx, 4'h0});
        check_eq("wb_data", wr_data, v ? d1 : d0);
        check_eq("wb_stall", stall, 1'b1);
        @(posedge clk); #1;
        scramble_lookup();
      end
      wr_rdy = 1'b0;
    end
    dly = $urandom_range(0, 3);
    for (int i = 0; i <= dly; i++) begin
      rd_rdy = (i == dly); wr_rdy = rand_bit();
      @(negedge clk);
      check_eq("rd_req", {wr_req, rd_req}, 2'b01);
      check_eq("rd_addr", rd_addr, {tg, idx, 4'h0});
      @(posedge clk); #1;
      scramble_lookup();
    end
    rd_rdy = 1'b0; wr_rdy = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (abort_at == b) begin
        ret_valid = 1'b0; ret_last = 1'b0; req_valid = 1'b0;
        #2 rstn = 1'b0;
        #1 check_all_zero("abort");
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      if ($urandom_range(0, 2) == 0) begin
        ret_valid = 1'b0; ret_last = rand_bit(); ret_data = $urandom;
        @(negedge clk);
        check_eq("gap_done", refill_done, 1'b0);
        check_eq("gap_stall", stall, 1'b1);
        @(posedge clk); #1;
        scramble_lookup();
      end
      ret_valid = 1'b1; ret_last = (b == nbeats - 1); ret_data = beats[b];
      words[k] = beats[b];
      k = (k + 1) % 4;
      @(negedge clk);
      check_eq("recv_stall", stall, 1'b1);
      check_eq("recv_nofill", {fill_we, refill_done}, 3'b000);
      @(posedge clk); #1;
      scramble_lookup();
    end
    ret_valid = 1'b0; ret_last = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check_eq("fill_we", fill_we, v ? 2'b10 : 2'b01);
    check_eq("fill_index", fill_index, idx);
    check_eq("fill_tag", fill_tag, tg);
    check_eq("fill_data", fill_data, {words[3], words[2], words[1], words[0]});
    check_eq("fill_done", refill_done, 1'b1);
    check_eq("fill_stall", stall, 1'b1);
    lru_m[idx] = ~v;
    rr_m = ~rr_m;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("post_fill", {fill_we, refill_done, stall}, 4'b0000);
  endtask

  initial begin
    logic [7:0]   ri;
    logic [1:0]   rh;
    int           nb;
    rstn = 1'b0; req_valid = 1'b0; req_index = '0; req_tag = '0; hit = '0; way_dirty = '0;
    way_tag0 = '0; way_tag1 = '0; way_data0 = '0; way_data1 = '0;
    wr_rdy = 1'b0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Clean miss with the documented beats.
    beats[0] = 32'h11111111; beats[1] = 32'h22222222;
    beats[2] = 32'h33333333; beats[3] = 32'h44444444;
    run_miss(8'h12, 20'hABCDE, 2'b00, 20'h0, 20'h0, '0, '0, 4, -1);

    // Reset mid-refill, then a clean miss must start from way0.
    run_miss(8'h20, 20'h12345, 2'b00, 20'h0, 20'h0, '0, '0, 4, 2);
    run_miss(8'h21, 20'h54321, 2'b00, 20'h0, 20'h0, '0, '0, 4, -1);

    // Dirty miss at set 5.
    run_hit(8'h05, 2'b10);
    run_miss(8'h05, 20'h0F0F0, 2'b11, 20'h00001, 20'h00002,
             128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 128'hCAFEF00D_CAFEF00D_CAFEF00D_CAFEF00D,
             4, -1);

    // Replacement behaviour around hits.
    run_hit(8'h03, 2'b01);
    run_miss(8'h03, 20'h33333, 2'b00, 20'h0, 20'h0, '0, '0, 4, -1);
    run_hit(8'h04, 2'b11);
    run_miss(8'h04, 20'h44444, 2'b00, 20'h0, 20'h0, '0, '0, 4, -1);

    // Early last and beat wrap.
    run_miss(8'h06, 20'h66666, 2'b00, 20'h0, 20'h0, '0, '0, 2, -1);
    for (int i = 0; i < 6; i++) beats[i] = 32'hA0000000 + i;
    run_miss(8'h07, 20'h77777, 2'b00, 20'h0, 20'h0, '0, '0, 6, -1);

    for (int it = 0; it < 150; it++) begin
      ri = 8'($urandom_range(0, 7));
      rh = 2'($urandom_range(0, 3));
      if (rh == 2'b00) begin
        nb = $urandom_range(1, 6);
        for (int i = 0; i < 8; i++) beats[i] = $urandom;
        run_miss(ri, 20'($urandom), 2'($urandom_range(0, 3)), 20'($urandom), 20'($urandom),
                 rand_line(), rand_line(), nb, ($urandom_range(0, 19) == 0) ? 1 : -1);
      end else begin
        run_hit(ri, rh);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
